// File: rtl/arb_pkg.sv
// Shared types and default sizing for the unified memory port arbiter.
package arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 2;

    // 4 bits covers the full legal latency range 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported unified memory: instruction fetch
// vs. load/store. Each access holds the memory port for MEM_LAT cycles, then
// issues a one-cycle ready pulse to the winner. All outputs are registered.
// MEM_LAT must be in 1..15; 0 is not a legal build.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_e             state_q, state_d;
    grant_e             gnt_q, gnt_d;
    grant_e             last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               en_d, we_d, if_ready_d, d_ready_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d, if_rdata_d, d_rdata_d;
    logic               pick_d;

    // State, counter, grant history and every output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_IF;
            last_q    <= GNT_IF;   // data wins the first tie
            cnt_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            mem_en    <= en_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
        end
    end

    // Next-state: grant in IDLE, count down in ACCESS, one ready cycle in RESP
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        en_d       = mem_en;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        pick_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // On a tie, whoever did not win last time goes first
                    pick_d  = d_req && (!if_req || (last_q == GNT_IF));
                    gnt_d   = pick_d ? GNT_D : GNT_IF;
                    en_d    = 1'b1;
                    we_d    = pick_d && d_we;
                    addr_d  = pick_d ? d_addr : if_addr;
                    wdata_d = pick_d ? d_wdata : '0;
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last memory cycle: read data is valid now
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        if (!mem_we) d_rdata_d = mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                    en_d    = 1'b0;
                    we_d    = 1'b0;
                    last_d  = gnt_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Requesters may still hold req while they see ready, so skip sampling
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected memory
// accesses and ready responses into queues, monitors pop and compare.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Main DUT (MEM_LAT=2)
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_en, mem_we;

    // Second DUT (MEM_LAT=1)
    logic        if_req1 = 0, d_req1 = 0, d_we1 = 0;
    logic [31:0] if_addr1 = 0, d_addr1 = 0, d_wdata1 = 0;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ready1, d_ready1, mem_en1, mem_we1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'hE3A0_1A01;
            32'h0000_0404: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign mem_rdata  = memfn(mem_addr);
    assign mem_rdata1 = memfn(mem_addr1);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    typedef struct {
        bit          is_d;
        int          cyc;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } acc_t;

    resp_t rq[$];
    resp_t rq1[$];
    acc_t  aq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Ready-pulse monitor for the main DUT
    task automatic mon_resp();
        resp_t r;
        if (if_ready && d_ready) chk("ready_overlap", 1, 0);
        if (if_ready || d_ready) begin
            if (rq.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                r = rq.pop_front();
                chk("ready_port", {31'b0, d_ready}, {31'b0, r.is_d});
                chk("ready_cycle", cyc, r.cyc);
                chk("rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
            end
        end
    endtask

    // Ready-pulse monitor for the MEM_LAT=1 DUT
    task automatic mon_resp1();
        resp_t r;
        if (if_ready1 || d_ready1) begin
            if (rq1.size() == 0) begin
                chk("unexpected_ready1", 1, 0);
            end else begin
                r = rq1.pop_front();
                chk("ready1_cycle", cyc, r.cyc);
                chk("rdata1", if_rdata1, r.rdata);
            end
        end
    endtask

    bit   en_prev = 0;
    int   en_len  = 0;
    acc_t cur;

    // Memory-port monitor: start cycle, we/wdata, address stability, hold length
    task automatic mon_acc();
        if (mem_en && !en_prev) begin
            if (aq.size() == 0) begin
                chk("unexpected_mem_en", 1, 0);
            end else begin
                cur = aq.pop_front();
                chk("acc_start", cyc, cur.cyc);
                chk("acc_we", {31'b0, mem_we}, {31'b0, cur.we});
                if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
            end
            en_len = 1;
        end else if (mem_en) begin
            en_len++;
        end
        if (mem_en) chk("acc_addr", mem_addr, cur.addr);
        if (!mem_en && en_prev) chk("acc_len", en_len, cur.len);
        en_prev = mem_en;
    endtask

    always @(negedge clk) begin
        mon_resp();
        mon_resp1();
        mon_acc();
    end

    task automatic wait_ready(input bit is_d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_d ? d_ready : if_ready) return;
        end
        chk(is_d ? "timeout_d_ready" : "timeout_if_ready", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        do_reset();

        // Idle after reset: nothing moves, read data stays 0
        repeat (10) begin
            @(negedge clk);
            chk("idle_mem_en", {31'b0, mem_en}, 0);
            chk("idle_ready", {30'b0, if_ready, d_ready}, 0);
            chk("idle_if_rdata", if_rdata, 0);
            chk("idle_d_rdata", d_rdata, 0);
        end

        // Single fetch from 0x4
        @(posedge clk); #1; n = cyc;
        aq.push_back('{n + 1, 0, 32'h4, 32'h0, 2});
        rq.push_back('{0, n + 3, 32'hE3A0_1A01});
        if_req = 1; if_addr = 32'h4;
        wait_ready(0);
        if_req = 0;

        // Tie right after reset: store wins, fetch follows
        @(posedge clk); #1;
        do_reset();
        n = cyc;
        aq.push_back('{n + 1, 1, 32'h400, 32'h14, 2});
        aq.push_back('{n + 5, 0, 32'h8, 32'h0, 2});
        rq.push_back('{1, n + 3, 32'h0});
        rq.push_back('{0, n + 7, memfn(32'h8)});
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h14;
        if_req = 1; if_addr = 32'h8;
        fork
            begin wait_ready(1); d_req = 0; d_we = 0; end
            begin wait_ready(0); if_req = 0; end
        join

        // Both held continuously: D, IF, D, IF every 4 cycles
        @(posedge clk); #1;
        do_reset();
        n = cyc;
        aq.push_back('{n + 1,  0, 32'h100, 32'h0, 2});
        aq.push_back('{n + 5,  0, 32'h10,  32'h0, 2});
        aq.push_back('{n + 9,  0, 32'h104, 32'h0, 2});
        aq.push_back('{n + 13, 0, 32'h14,  32'h0, 2});
        rq.push_back('{1, n + 3,  memfn(32'h100)});
        rq.push_back('{0, n + 7,  memfn(32'h10)});
        rq.push_back('{1, n + 11, memfn(32'h104)});
        rq.push_back('{0, n + 15, memfn(32'h14)});
        d_req = 1; d_we = 0; d_addr = 32'h100;
        if_req = 1; if_addr = 32'h10;
        fork
            begin wait_ready(1); d_addr = 32'h104; wait_ready(1); d_req = 0; end
            begin wait_ready(0); if_addr = 32'h14; wait_ready(0); if_req = 0; end
        join

        // Load aborted by reset in its first access cycle
        @(posedge clk); #1; n = cyc;
        aq.push_back('{n + 1, 0, 32'h404, 32'h0, 1});
        d_req = 1; d_we = 0; d_addr = 32'h404;
        @(posedge clk); #1;
        rst_n = 0; d_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("abort_mem_en", {31'b0, mem_en}, 0);
        chk("abort_mem_we", {31'b0, mem_we}, 0);
        chk("abort_d_rdata", d_rdata, 0);
        chk("abort_if_rdata", if_rdata, 0);
        repeat (4) @(negedge clk);

        // Fresh load after the abort completes normally
        @(posedge clk); #1; n = cyc;
        aq.push_back('{n + 1, 0, 32'h404, 32'h0, 2});
        rq.push_back('{1, n + 3, 32'hDEAD_BEEF});
        d_req = 1; d_addr = 32'h404;
        wait_ready(1);
        d_req = 0;

        // MEM_LAT=1 build: one-cycle access, ready two cycles after sampling
        @(posedge clk); #1; n = cyc;
        rq1.push_back('{0, n + 2, memfn(32'hC)});
        if_req1 = 1; if_addr1 = 32'hC;
        @(negedge clk);
        chk("lat1_en_n", {31'b0, mem_en1}, 0);
        @(negedge clk);
        chk("lat1_en_n1", {31'b0, mem_en1}, 1);
        chk("lat1_addr", mem_addr1, 32'hC);
        chk("lat1_we", {31'b0, mem_we1}, 0);
        @(negedge clk);
        chk("lat1_en_n2", {31'b0, mem_en1}, 0);
        chk("lat1_ready_n2", {31'b0, if_ready1}, 1);
        if_req1 = 0;
        @(negedge clk);
        chk("lat1_ready_n3", {31'b0, if_ready1}, 0);

        repeat (6) @(negedge clk);
        chk("resp_queue_empty", rq.size(), 0);
        chk("acc_queue_empty", aq.size(), 0);
        chk("resp1_queue_empty", rq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between two requesters: the IF-stage instruction fetch and the MEM-stage load/store.
- Sits between the pipeline stages and the memory array, which holds program words at byte addresses 0, 4, 8, … and data.
- Sequences each access over a fixed multi-cycle memory latency and returns a one-cycle ready pulse to the winning requester; the pipeline freezes on a pending request with ready low.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data and instruction width in bits.
- MEM_LAT, 2, number of cycles the memory port is held per access; legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch byte address (PC).
- if_rdata  out  DATA_W  fetched instruction word.
- if_ready  out  1  one-cycle pulse; fetch done, if_rdata valid.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result.
- d_ready  out  1  one-cycle pulse; data access done.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last cycle of an access.

Behaviour:
- The FSM has three states: IDLE, ACCESS and RESP. Every output is registered.
- Reset (rst_n=0 at an edge):
  - state becomes IDLE, the counter is 0, and last_grant becomes IF, so data wins the first tie.
  - mem_en, mem_we, if_ready and d_ready go to 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata go to 0.
- IDLE:
  - With neither request pending, the block stays in IDLE.
  - With one request pending, that requester is granted.
  - With both pending, the requester that was not in last_grant is granted. This alternates grants and prevents starvation.
  - On a grant: latch the grant, address, we and wdata; drive mem_en=1 and mem_we, mem_addr and mem_wdata from the latch; set the counter to MEM_LAT-1; go to ACCESS.
  - A fetch grant always drives mem_we=0.
- ACCESS:
  - mem_* outputs stay stable for exactly MEM_LAT cycles.
  - The counter decrements each cycle.
  - When the counter reads 0, mem_rdata is captured into if_rdata, or into d_rdata for a load. A store leaves d_rdata unchanged.
  - At that same edge, mem_en and mem_we go to 0, the matching ready pulse is asserted, last_grant is updated, and the state moves to RESP.
- RESP:
  - The ready pulse is high for exactly one cycle.
  - Requests are not sampled in this cycle, because the requester may still hold req while it observes ready.
  - Next state is IDLE.
- Latency, with the request first seen high in IDLE at cycle n:
  - mem_en is high in cycles n+1 through n+MEM_LAT.
  - Ready is high in cycle n+MEM_LAT+1.
  - Peak throughput is one access per MEM_LAT+2 cycles.
- Protocol rules:
  - A requester must not change its request signals while waiting.
  - If a requester drops req mid-access, the access still completes from the latched copy and its ready pulse is still issued.
- if_ready and d_ready are never high in the same cycle.
- if_rdata and d_rdata hold their last value until their next completion.
- Reset mid-access: the access is abandoned, mem_en and mem_we are 0 from the next cycle, no ready pulse is issued, and rdata outputs return to 0.
- Counter width is 4 bits, enough for MEM_LAT up to 15.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - grant enum {GNT_IF, GNT_D};
  - the default values of ADDR_W, DATA_W and MEM_LAT.
- No sub-module. The latency counter is a few lines inside the FSM and is not worth splitting out.

Test Plan:
- Reset release, MEM_LAT=2, no requests for 10 cycles -> mem_en, if_ready and d_ready stay 0; if_rdata and d_rdata stay 0x00000000.
- if_req=1 with if_addr=0x00000004 at cycle 0, memory returns 0xE3A01A01 -> mem_en=1 with mem_addr=4 in cycles 1–2; if_ready=1 in cycle 3 only; if_rdata=0xE3A01A01.
- Both requests at cycle 0 after reset, d_we=1, d_addr=0x400, d_wdata=0x14, if_addr=0x8 -> data first (mem_we=1, mem_addr=0x400, d_ready in cycle 3); then the fetch is granted in cycle 4 with mem_we=0 and if_ready in cycle 7.
- Both requests held continuously with a new address after each ready -> grants alternate D, IF, D, IF; no ready pulse ever overlaps; each requester completes one access per 8 cycles.
- Data load from 0x404 with memory returning 0xDEADBEEF, rst_n=0 for one edge in the first ACCESS cycle -> mem_en=0 from the next cycle; no d_ready; d_rdata=0; a new request afterwards completes normally.
- MEM_LAT=1 build, a single fetch -> mem_en high for 1 cycle; if_ready 2 cycles after the request is sampled.
